// File: rtl/cluster_event_pkg.sv
// Shared definitions for the per-core cluster event controller:
// register offsets, FSM state type and the lowest-set-bit encoder.
package cluster_event_pkg;

    localparam logic [31:0] EVT_MASK_OFS       = 32'h00;
    localparam logic [31:0] EVT_BUFFER_OFS     = 32'h04;
    localparam logic [31:0] EVT_BUF_MASKED_OFS = 32'h08;
    localparam logic [31:0] EVT_BUF_CLEAR_OFS  = 32'h0C;
    localparam logic [31:0] EVT_WAIT_OFS       = 32'h10;
    localparam logic [31:0] EVT_WAIT_CLR_OFS   = 32'h14;
    localparam logic [31:0] EVT_IRQ_MASK_OFS   = 32'h18;

    typedef enum logic [1:0] {ACTIVE, IDLE_WAIT, SLEEP, RESUME} evt_ctrl_state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [4:0] lowest_set_bit(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i[4:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/cluster_event_core_ctrl.sv
// Per-core event controller: sticky event buffer with software mask, a
// core-private register port and wait-for-event clock gating.
// Optional feature macro: CLUSTER_EVENT_IRQ_EN (adds IRQ mask register,
// irq_o/irq_id_o outputs, irq_ack_i input and IRQ-driven wake-up).
module cluster_event_core_ctrl
    import cluster_event_pkg::*;
#(
    parameter int unsigned NB_EVT     = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NB_EVT-1:0]     events_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    input  logic                  core_busy_i,
`ifdef CLUSTER_EVENT_IRQ_EN
    input  logic                  irq_ack_i,
    output logic                  irq_o,
    output logic [4:0]            irq_id_o,
`endif
    output logic                  core_clk_en_o
);

    evt_ctrl_state_e   state_q, state_d;
    logic [NB_EVT-1:0] mask_q, mask_d;
    logic [NB_EVT-1:0] buf_q, buf_d;
    logic              wait_clr_q, wait_clr_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       addr_w;
    logic [NB_EVT-1:0] w1c_clr, ack_clr, wait_clr, buf_pre, m;
    logic              wake;
    logic              unused_addr;

    assign addr_w      = 32'({addr_i[ADDR_WIDTH-1:2], 2'b00});
    assign unused_addr = ^addr_i[1:0];
    assign gnt_o       = req_i & (state_q == ACTIVE);
    assign w1c_clr     = (gnt_o && we_i && addr_w == EVT_BUF_CLEAR_OFS) ? wdata_i : '0;

`ifdef CLUSTER_EVENT_IRQ_EN
    logic [NB_EVT-1:0] irq_mask_q, irq_mask_d;
    logic [NB_EVT-1:0] irq_vec;

    assign irq_vec  = buf_q & irq_mask_q;
    assign irq_o    = |irq_vec;
    assign irq_id_o = lowest_set_bit(irq_vec);
    assign ack_clr  = (irq_ack_i && irq_o) ? (NB_EVT'(1) << irq_id_o) : '0;
`else
    assign ack_clr  = '0;
`endif

    // Pending mask is evaluated on the buffer as it will be after this cycle's
    // clears and sets, so an event arriving in the grant cycle is seen.
    assign buf_pre = (buf_q & ~w1c_clr & ~ack_clr) | events_i;
    assign m       = buf_pre & mask_q;

`ifdef CLUSTER_EVENT_IRQ_EN
    assign wake = (|m) | irq_o;
`else
    assign wake = |m;
`endif

    // Wake-up re-enables the clock combinationally in the same cycle.
    assign core_clk_en_o = !((state_q == SLEEP) && !wake);
    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;

    // Set wins over every clear source in the same cycle.
    assign buf_d = (buf_pre & ~wait_clr) | events_i;

    // Register decode, wait sequencing and response generation.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        wait_clr_d = wait_clr_q;
        rvalid_d   = 1'b0;
        rdata_d    = '0;
        wait_clr   = '0;
`ifdef CLUSTER_EVENT_IRQ_EN
        irq_mask_d = irq_mask_q;
`endif
        unique case (state_q)
            ACTIVE: begin
                if (gnt_o) begin
                    rvalid_d = 1'b1;
                    if (we_i) begin
                        if (addr_w == EVT_MASK_OFS) mask_d = wdata_i;
`ifdef CLUSTER_EVENT_IRQ_EN
                        if (addr_w == EVT_IRQ_MASK_OFS) irq_mask_d = wdata_i;
`endif
                    end else begin
                        case (addr_w)
                            EVT_MASK_OFS:       rdata_d = mask_q;
                            EVT_BUFFER_OFS:     rdata_d = buf_q;
                            EVT_BUF_MASKED_OFS: rdata_d = buf_q & mask_q;
                            EVT_WAIT_OFS, EVT_WAIT_CLR_OFS: begin
                                if (|m) begin
                                    rdata_d = m;
                                    if (addr_w == EVT_WAIT_CLR_OFS) wait_clr = m;
                                end else begin
                                    rvalid_d   = 1'b0;
                                    state_d    = IDLE_WAIT;
                                    wait_clr_d = (addr_w == EVT_WAIT_CLR_OFS);
                                end
                            end
`ifdef CLUSTER_EVENT_IRQ_EN
                            EVT_IRQ_MASK_OFS:   rdata_d = irq_mask_q;
`endif
                            default:            rdata_d = '0;
                        endcase
                    end
                end
            end
            IDLE_WAIT: begin
                if (wake) state_d = RESUME;
                else if (!core_busy_i) state_d = SLEEP;
            end
            SLEEP: begin
                if (wake) state_d = RESUME;
            end
            RESUME: begin
                rvalid_d   = 1'b1;
                rdata_d    = m;
                if (wait_clr_q) wait_clr = m;
                wait_clr_d = 1'b0;
                state_d    = ACTIVE;
            end
            default: state_d = ACTIVE;
        endcase
    end

    // State and register storage; reset drops any pending wait.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ACTIVE;
            mask_q     <= '0;
            buf_q      <= '0;
            wait_clr_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            buf_q      <= buf_d;
            wait_clr_q <= wait_clr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef CLUSTER_EVENT_IRQ_EN
    // IRQ mask storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_mask_q <= '0;
        else         irq_mask_q <= irq_mask_d;
    end
`endif

endmodule

// File: tb/tb_cluster_event_core_ctrl.sv
// Scoreboard bench for cluster_event_core_ctrl (default build, IRQ feature off).
module tb_cluster_event_core_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] events = '0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        busy = 1'b0;
    logic        clk_en;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    localparam logic [4:0] A_MASK  = 5'h00;
    localparam logic [4:0] A_BUF   = 5'h04;
    localparam logic [4:0] A_BUFM  = 5'h08;
    localparam logic [4:0] A_CLR   = 5'h0C;
    localparam logic [4:0] A_WAIT  = 5'h10;
    localparam logic [4:0] A_WAITC = 5'h14;

    cluster_event_core_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .events_i      (events),
        .req_i         (req),
        .we_i          (we),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .gnt_o         (gnt),
        .rvalid_o      (rvalid),
        .rdata_o       (rdata),
        .core_busy_i   (busy),
        .core_clk_en_o (clk_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response pops the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata 0x%08h, required no response", rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, rdata, e.val);
            end
        end
    end

    task automatic access(input logic w, input logic [4:0] a, input logic [31:0] d,
                          input string name, input logic [31:0] exp);
        exp_t e;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        e.name = name; e.val = exp;
        exp_q.push_back(e);
        @(negedge clk);
        check({name, "_gnt"}, 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        check({name, "_latency"}, 32'(rvalid), 32'd1);
    endtask

    task automatic issue_wait(input logic [4:0] a);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] v);
        @(posedge clk); #1; events = v;
        @(posedge clk); #1; events = '0;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic fell;
        int   cyc;

        // Reset state
        #12;
        check("rst_clk_en", 32'(clk_en), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // 1. Mask read-back and empty buffer
        access(1'b1, A_MASK, 32'h0000_0300, "wr_mask", 32'h0);
        access(1'b0, A_MASK, 32'h0, "rd_mask", 32'h0000_0300);
        access(1'b0, A_BUF, 32'h0, "rd_buf_reset", 32'h0);
        access(1'b1, 5'h1C, 32'hFFFF_FFFF, "wr_unmapped", 32'h0);
        access(1'b0, 5'h18, 32'h0, "rd_unmapped", 32'h0);
        access(1'b0, A_MASK, 32'h0, "rd_mask_kept", 32'h0000_0300);

        // 2. Sticky buffer, masked view, W1C racing a set
        pulse(32'h0000_0104);
        access(1'b0, A_BUF, 32'h0, "rd_buf_104", 32'h0000_0104);
        access(1'b0, A_BUFM, 32'h0, "rd_bufm_100", 32'h0000_0100);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = A_CLR; wdata = 32'h0000_0100; events = 32'h0000_0100;
        e.name = "w1c_race"; e.val = 32'h0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; events = '0;
        access(1'b0, A_BUF, 32'h0, "rd_buf_set_wins", 32'h0000_0104);
        access(1'b1, A_CLR, 32'h0000_0104, "w1c_all", 32'h0);
        access(1'b0, A_BUF, 32'h0, "rd_buf_cleared", 32'h0);

        // 3. Sleep until bit 16, WAIT_CLR clears it
        access(1'b1, A_MASK, 32'h0001_0000, "wr_mask16", 32'h0);
        busy = 1'b0;
        issue_wait(A_WAITC);
        repeat (3) @(negedge clk);
        check("sleep_clk_en", 32'(clk_en), 32'd0);
        @(posedge clk); #1; req = 1'b1; addr = A_MASK;
        @(negedge clk);
        check("sleep_no_gnt", 32'(gnt), 32'd0);
        @(posedge clk); #1; req = 1'b0;
        repeat (18) @(posedge clk);
        #1; events = 32'h0001_0000;
        e.name = "wait_clr_wake"; e.val = 32'h0001_0000;
        exp_q.push_back(e);
        @(negedge clk);
        check("wake_same_cycle", 32'(clk_en), 32'd1);
        @(posedge clk); #1; events = '0;
        drain("wake");
        access(1'b0, A_BUF, 32'h0, "rd_buf_after_wclr", 32'h0);

        // 4. WAIT with event already pending: immediate answer, buffer kept
        pulse(32'h0001_0000);
        access(1'b0, A_WAIT, 32'h0, "wait_hit", 32'h0001_0000);
        check("wait_hit_clk_en", 32'(clk_en), 32'd1);
        access(1'b0, A_BUF, 32'h0, "rd_buf_kept", 32'h0001_0000);
        access(1'b1, A_CLR, 32'h0001_0000, "w1c16", 32'h0);

        // 5. Core stays busy; event arrives before gating could happen
        busy = 1'b1;
        issue_wait(A_WAIT);
        fell = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            events = (i == 5) ? 32'h0001_0000 : 32'h0;
            if (i == 5) begin
                e.name = "wait_busy"; e.val = 32'h0001_0000;
                exp_q.push_back(e);
            end
            @(negedge clk);
            if (clk_en !== 1'b1) fell = 1'b1;
        end
        events = '0;
        busy = 1'b0;
        check("busy_no_gate", 32'(fell), 32'd0);
        drain("busy");
        access(1'b1, A_CLR, 32'hFFFF_FFFF, "w1c_busy", 32'h0);

        // 6. Asynchronous reset in the middle of sleep
        issue_wait(A_WAITC);
        cyc = 0;
        while (clk_en !== 1'b0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("sleep2_clk_en", 32'(clk_en), 32'd0);
        pulse(32'h0000_0008);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_sleep_clk_en", 32'(clk_en), 32'd1);
        check("rst_sleep_rvalid", 32'(rvalid), 32'd0);
        check("rst_sleep_rdata", rdata, 32'd0);
        #10;
        rst_n = 1'b1;
        access(1'b0, A_MASK, 32'h0, "rd_mask_after_rst", 32'h0);
        access(1'b0, A_BUF, 32'h0, "rd_buf_after_rst", 32'h0);
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
